// File: rtl/multichannel_delay_effect.sv
// Multichannel delay/echo: NUM_CH channels share one time-multiplexed circular RAM.
// Optional cross-channel (ping-pong) feedback is enabled by defining PINGPONG_EN.
module multichannel_delay_effect #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FEEDBACK_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   audio_in,
    input  logic [ADDR_WIDTH-1:0]          delay_samples,
    input  logic [FEEDBACK_WIDTH-1:0]      feedback_amount,
    input  logic [7:0]                     effect_amount,
    input  logic                           mode,
`ifdef PINGPONG_EN
    input  logic                           pingpong,
`endif
    output logic [NUM_CH*DATA_WIDTH-1:0]   audio_out,
    output logic                           audio_out_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int DW   = DATA_WIDTH;
    localparam int AW   = ADDR_WIDTH;
    localparam int FW   = FEEDBACK_WIDTH;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MW   = DW + 9;
    localparam int SW   = DW + FW + 2;
    localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_CALC, S_MIX} state_t;

    state_t state, state_nxt;

    logic [CH_W-1:0]        ch_idx, nbr_idx, rd_idx_q;
    logic                   last_ch, rd_pending, fill_short, pp_act;
    logic                   ram_we, ram_re;
    logic [CH_W+AW-1:0]     ram_waddr, ram_raddr;
    logic [DW-1:0]          ram_rdata;
    logic [DW-1:0]          ram [2**(CH_W+AW)];

    logic signed [DW-1:0]   in_q  [NUM_CH];
    logic signed [DW-1:0]   del   [NUM_CH];
    logic signed [MW-1:0]   dry_q [NUM_CH];
    logic signed [MW-1:0]   wet_q [NUM_CH];
    logic signed [DW-1:0]   mix_out [NUM_CH];

    logic [AW-1:0]          d_q, wr_ptr, fill_cnt;
    logic [FW-1:0]          fb_q;
    logic [7:0]             e_q;
    logic                   mode_q;

    logic signed [DW-1:0]   cur_in, cur_del, fb_src, buf_in;
    logic signed [SW-1:0]   fb_prod, fb_sum;
    logic signed [MW-1:0]   dry_nxt, wet_nxt;

    // ---------------- FSM ----------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (sample_valid) state_nxt = S_RD;
            S_RD:   if (last_ch) state_nxt = S_RDW;
            S_RDW:  state_nxt = S_CALC;
            S_CALC: if (last_ch) state_nxt = S_MIX;
            S_MIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_re = (state == S_RD);
        ram_we = (state == S_CALC);
    end

    // ---------------- shared RAM ----------------
    assign ram_raddr = {ch_idx, wr_ptr - d_q};
    assign ram_waddr = {ch_idx, wr_ptr};

    // NOTE: the delay RAM has no reset; stale contents are hidden by the fill mask instead.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= buf_in;
        if (ram_re) ram_rdata <= ram[ram_raddr];
    end

`ifdef PINGPONG_EN
    logic pp_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            pp_q <= 1'b0;
        else if (state == S_IDLE && sample_valid) pp_q <= pingpong;
    end
    assign pp_act = mode_q & pp_q;
`else
    assign pp_act = 1'b0;
`endif

    // ---------------- per-channel datapath ----------------
    assign last_ch    = (ch_idx == LAST_CH);
    assign fill_short = (fill_cnt < d_q);

    always_comb begin
        nbr_idx = last_ch ? '0 : ch_idx + 1'b1;
        cur_in  = in_q[ch_idx];
        cur_del = del[ch_idx];
        fb_src  = pp_act ? del[nbr_idx] : cur_del;
        fb_prod = SW'(fb_src) * SW'($signed({1'b0, fb_q}));
        fb_sum  = SW'(cur_in) + (fb_prod >>> FW);
        // Saturate when the wide sum no longer sign-extends cleanly into DW bits.
        if (!mode_q)
            buf_in = cur_in;
        else if (&fb_sum[SW-1:DW-1] || ~|fb_sum[SW-1:DW-1])
            buf_in = fb_sum[DW-1:0];
        else
            buf_in = fb_sum[SW-1] ? SAT_MIN : SAT_MAX;
        dry_nxt = MW'(cur_in)  * MW'($signed({1'b0, 8'd255 - e_q}));
        wet_nxt = MW'(cur_del) * MW'($signed({1'b0, e_q}));
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            mix_out[i] = DW'((dry_q[i] + wet_q[i]) >>> 8);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_idx          <= '0;
            rd_idx_q        <= '0;
            rd_pending      <= 1'b0;
            d_q             <= AW'(1);
            fb_q            <= '0;
            e_q             <= '0;
            mode_q          <= 1'b0;
            wr_ptr          <= '0;
            fill_cnt        <= '0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                in_q[i]  <= '0;
                del[i]   <= '0;
                dry_q[i] <= '0;
                wet_q[i] <= '0;
            end
        end else begin
            audio_out_valid <= 1'b0;
            rd_pending      <= ram_re;
            rd_idx_q        <= ch_idx;
            ch_idx          <= (state == S_RD || state == S_CALC) ? nbr_idx : '0;
            // Registered RAM data lands one cycle after its read was issued.
            if (rd_pending)
                del[rd_idx_q] <= fill_short ? '0 : $signed(ram_rdata);
            if (sample_valid && busy)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (sample_valid) begin
                    for (int i = 0; i < NUM_CH; i++)
                        in_q[i] <= $signed(audio_in[i*DW +: DW]);
                    d_q    <= (delay_samples == '0) ? AW'(1) : delay_samples;
                    fb_q   <= feedback_amount;
                    e_q    <= effect_amount;
                    mode_q <= mode;
                    busy   <= 1'b1;
                end
                S_CALC: begin
                    dry_q[ch_idx] <= dry_nxt;
                    wet_q[ch_idx] <= wet_nxt;
                end
                S_MIX: begin
                    for (int i = 0; i < NUM_CH; i++)
                        audio_out[i*DW +: DW] <= mix_out[i];
                    audio_out_valid <= 1'b1;
                    wr_ptr          <= wr_ptr + 1'b1;
                    if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
                    busy            <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
